// File: rtl/vga_timing_gen.sv
// SVGA raster timing generator: sync pulses, pixel coordinates, visible flag and line/frame strobes.
// Optional lookahead outputs (NEXT_X/NEXT_Y/NEXT_VISIBLE) are built when VGA_TIMING_LOOKAHEAD_EN is defined.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FRONT   = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BACK    = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FRONT   = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BACK    = 23,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic        CLK_40M,
  input  logic        RESET_N,
  input  logic        EN,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [10:0] PIXEL_X,
  output logic [9:0]  PIXEL_Y,
  output logic        VISIBLE,
  output logic        LINE_START,
  output logic        FRAME_START
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [10:0] NEXT_X,
  output logic [9:0]  NEXT_Y,
  output logic        NEXT_VISIBLE
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Timing totals must fit the 11-bit / 10-bit coordinate ports.
  if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_h_range_chk
    $error("vga_timing_gen: H_TOTAL %0d does not fit 11 bits", H_TOTAL);
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_v_range_chk
    $error("vga_timing_gen: V_TOTAL %0d does not fit 10 bits", V_TOTAL);
  end

  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;
  logic        h_wrap;
  logic        vis_cur, hs_act, vs_act;

  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    h_next  = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_next  = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    vis_cur = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_act  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_act  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  end

  always_ff @(posedge CLK_40M or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt       <= 11'd0;
      v_cnt       <= 10'd0;
      PIXEL_X     <= 11'd0;
      PIXEL_Y     <= 10'd0;
      VISIBLE     <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      HSYNC       <= ~HSYNC_POL;
      VSYNC       <= ~VSYNC_POL;
    end else if (EN) begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      PIXEL_X     <= h_cnt;
      PIXEL_Y     <= v_cnt;
      VISIBLE     <= vis_cur;
      LINE_START  <= (h_cnt == 11'd0);
      FRAME_START <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
      HSYNC       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      VSYNC       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
    end else begin
      // Strobes must not stretch across disabled clocks.
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  always_ff @(posedge CLK_40M or negedge RESET_N) begin
    if (!RESET_N) begin
      NEXT_X       <= 11'd0;
      NEXT_Y       <= 10'd0;
      NEXT_VISIBLE <= 1'b1;
    end else if (EN) begin
      NEXT_X       <= h_next;
      NEXT_Y       <= v_next;
      NEXT_VISIBLE <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for line timing, shrunken instance for frame timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk;
  logic rst_a, en_a, rst_b, en_b;

  logic        a_hs, a_vs, a_vis, a_ls, a_fs;
  logic [10:0] a_x;
  logic [9:0]  a_y;
  logic        b_hs, b_vs, b_vis, b_ls, b_fs;
  logic [10:0] b_x;
  logic [9:0]  b_y;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [10:0] a_nx, b_nx;
  logic [9:0]  a_ny, b_ny;
  logic        a_nv, b_nv;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  vga_timing_gen u_dut_a (
    .CLK_40M(clk), .RESET_N(rst_a), .EN(en_a),
    .HSYNC(a_hs), .VSYNC(a_vs), .PIXEL_X(a_x), .PIXEL_Y(a_y),
    .VISIBLE(a_vis), .LINE_START(a_ls), .FRAME_START(a_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .NEXT_X(a_nx), .NEXT_Y(a_ny), .NEXT_VISIBLE(a_nv)
`endif
  );

  // 16 clocks x 12 lines, active-low syncs: hsync x in [10,13), vsync y in [7,9).
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_dut_b (
    .CLK_40M(clk), .RESET_N(rst_b), .EN(en_b),
    .HSYNC(b_hs), .VSYNC(b_vs), .PIXEL_X(b_x), .PIXEL_Y(b_y),
    .VISIBLE(b_vis), .LINE_START(b_ls), .FRAME_START(b_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .NEXT_X(b_nx), .NEXT_Y(b_ny), .NEXT_VISIBLE(b_nv)
`endif
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int hs_cnt, ls_cnt, hs_first_x, vs_cnt, vs_first_x, vs_first_y, fs_cnt;
    int last_x, last_y, n_en;
    logic [10:0] prev_nx;
    logic [9:0]  prev_ny;
    logic        prev_nv;
    prev_nx = '0; prev_ny = '0; prev_nv = 1'b0;

    rst_a = 1'b0; en_a = 1'b1; rst_b = 1'b0; en_b = 1'b1;
    @(negedge clk);
    step(2);
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_vis", a_vis, 0);
    chk("rst_ls", a_ls, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_hs", a_hs, 0);
    chk("rst_vs", a_vs, 0);
    chk("rst_b_hs", b_hs, 1);
    chk("rst_b_vs", b_vs, 1);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    chk("rst_nx", a_nx, 0);
    chk("rst_ny", a_ny, 0);
    chk("rst_nv", a_nv, 1);
`endif

    // First enabled edge after release
    rst_a = 1'b1;
    step(1);
    chk("first_x", a_x, 0);
    chk("first_y", a_y, 0);
    chk("first_vis", a_vis, 1);
    chk("first_ls", a_ls, 1);
    chk("first_fs", a_fs, 1);
    chk("first_hs", a_hs, 0);
    chk("first_vs", a_vs, 0);

    step(799);
    chk("x799_vis", a_vis, 1);
    step(1);
    chk("x800_x", a_x, 800);
    chk("x800_vis", a_vis, 0);
    step(39);
    chk("x839_hs", a_hs, 0);
    step(1);
    chk("x840_hs", a_hs, 1);
    step(127);
    chk("x967_hs", a_hs, 1);
    step(1);
    chk("x968_hs", a_hs, 0);
    step(87);
    chk("x1055_x", a_x, 1055);
    chk("x1055_ls", a_ls, 0);
    step(1);
    chk("wrap_x", a_x, 0);
    chk("wrap_y", a_y, 1);
    chk("wrap_ls", a_ls, 1);
    chk("wrap_fs", a_fs, 0);
    chk("wrap_vis", a_vis, 1);

    // One full line: sync width, strobe count
    hs_cnt = 0; ls_cnt = 0; hs_first_x = -1;
    for (int i = 0; i < 1056; i++) begin
      if (a_hs) begin
        hs_cnt++;
        if (hs_first_x < 0) hs_first_x = int'(a_x);
      end
      if (a_ls) ls_cnt++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      if (i > 0) begin
        chk("la_line_x", a_x, prev_nx);
        chk("la_line_vis", a_vis, prev_nv);
      end
      prev_nx = a_nx; prev_nv = a_nv;
`endif
      step(1);
    end
    chk("line_hs_width", hs_cnt, 128);
    chk("line_hs_start", hs_first_x, 840);
    chk("line_ls_count", ls_cnt, 1);
    chk("line2_ls", a_ls, 1);
    chk("line2_x", a_x, 0);
    chk("line2_y", a_y, 2);

    // Hold EN low for 10 clocks at x=0
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_x", a_x, 0);
      chk("hold_ls", a_ls, 0);
    end
    chk("hold_y", a_y, 2);
    chk("hold_vis", a_vis, 1);
    en_a = 1'b1;
    n_en = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      n_en++;
      if (a_ls) break;
    end
    chk("hold_line_len", n_en, 1056);
    chk("hold_after_y", a_y, 3);

    // Asynchronous reset between edges at (400,3)
    step(400);
    chk("pre_rst_x", a_x, 400);
    #5 rst_a = 1'b0;
    #1;
    chk("async_x", a_x, 0);
    chk("async_y", a_y, 0);
    chk("async_vis", a_vis, 0);
    chk("async_ls", a_ls, 0);
    @(negedge clk);
    rst_a = 1'b1;
    step(1);
    chk("restart_fs", a_fs, 1);
    chk("restart_x", a_x, 0);

    // Shrunken instance: frame timing
    rst_b = 1'b1;
    step(1);
    chk("b_first_fs", b_fs, 1);
    chk("b_first_hs", b_hs, 1);
    chk("b_first_vs", b_vs, 1);
    vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; fs_cnt = 0; hs_cnt = 0;
    last_x = -1; last_y = -1;
    for (int i = 0; i < 192; i++) begin
      if (b_vs == 1'b0) begin
        vs_cnt++;
        if (vs_first_x < 0) begin
          vs_first_x = int'(b_x);
          vs_first_y = int'(b_y);
        end
      end
      if (b_fs) fs_cnt++;
      if (i < 16 && b_hs == 1'b0) hs_cnt++;
      if (i == 191) begin
        last_x = int'(b_x);
        last_y = int'(b_y);
      end
`ifdef VGA_TIMING_LOOKAHEAD_EN
      if (i > 0) begin
        chk("la_frame_x", b_x, prev_nx);
        chk("la_frame_y", b_y, prev_ny);
        chk("la_frame_vis", b_vis, prev_nv);
      end
      prev_nx = b_nx; prev_ny = b_ny; prev_nv = b_nv;
`endif
      step(1);
    end
`ifdef VGA_TIMING_LOOKAHEAD_EN
    chk("la_wrap_x", b_x, prev_nx);
    chk("la_wrap_y", b_y, prev_ny);
`endif
    chk("b_vs_width", vs_cnt, 32);
    chk("b_vs_start_x", vs_first_x, 0);
    chk("b_vs_start_y", vs_first_y, 7);
    chk("b_fs_count", fs_cnt, 1);
    chk("b_hs_width", hs_cnt, 3);
    chk("b_last_x", last_x, 15);
    chk("b_last_y", last_y, 11);
    chk("b_frame2_fs", b_fs, 1);
    chk("b_frame2_y", b_y, 0);

    step(84);
    chk("b_pre_rst_x", b_x, 4);
    chk("b_pre_rst_y", b_y, 5);
    #5 rst_b = 1'b0;
    #1;
    chk("b_async_x", b_x, 0);
    chk("b_async_y", b_y, 0);
    chk("b_async_hs", b_hs, 1);
    @(negedge clk);
    rst_b = 1'b1;
    step(1);
    chk("b_restart_fs", b_fs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
